// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter that lets four requesters share one 4:1 single-bit mux.
// It drives the mux select and a one-hot grant, and it keeps a grant until
// the owner drops its request. Between two owners there is always exactly
// one GAP cycle with no grant, so the mux output never switches directly
// from one owner to another.
//
// Optional feature: define ARB_HOLD_TIMEOUT_EN to enable the hold timeout.
// An owner that still requests after MAX_HOLD grant cycles is then forced
// off, and o_timeout pulses for that GAP cycle. When the macro is not
// defined there is no counter, o_timeout is always 0, and MAX_HOLD has no
// effect.
//
// Parameters:
//   MAX_HOLD   maximum number of grant cycles per owner (2..255), timeout only
//
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_en       arbitration enable; 0 blocks new grants
//   i_req[3:0] level-sensitive request per requester
//   o_gnt[3:0] registered one-hot grant
//   o_sel[1:0] registered mux select (current or last owner)
//   o_busy     registered, 1 while a grant is active
//   o_timeout  registered one-cycle pulse when a grant is forcibly ended
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic [3:0] i_req,
   output logic [3:0] o_gnt,
   output logic [1:0] o_sel,
   output logic       o_busy,
   output logic       o_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Reject an illegal hold limit at elaboration instead of building
   // a counter that would misbehave.
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_badMaxHold
      $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
   end

   state_t     r_state, w_stateNext;
   logic [3:0] r_gnt, w_gntNext;
   logic [1:0] r_sel, w_selNext;
   logic       r_busy, w_busyNext;
   logic       r_timeout, w_timeoutNext;
   logic [1:0] r_ptr, w_ptrNext;

   logic       w_found;
   logic [1:0] w_winner;
   logic       w_holdExpired;

`ifdef ARB_HOLD_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   logic [CNT_W-1:0] r_cnt, w_cntNext;

   // The counter is 0 during the first grant cycle, so reaching MAX_HOLD-1
   // means the owner is in its MAX_HOLD-th cycle.
   assign w_holdExpired = (r_cnt == CNT_W'(MAX_HOLD - 1));
`else
   assign w_holdExpired = 1'b0;
`endif

   // The search runs from the highest offset down to the lowest, so the
   // request closest to r_ptr is written last and wins. The 2-bit sum
   // wraps modulo 4.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      for (int i = 3; i >= 0; i--) begin
         if (i_req[r_ptr + 2'(i)]) begin
            w_found  = 1'b1;
            w_winner = r_ptr + 2'(i);
         end
      end
   end

   // While in GRANT, the owner is the value held in r_sel. On the way to
   // GAP, a timeout is reported only if the owner still requests. If the
   // owner releases in the same cycle the counter expires, this counts
   // as a normal release.
   always_comb begin
      w_stateNext   = r_state;
      w_gntNext     = r_gnt;
      w_selNext     = r_sel;
      w_busyNext    = r_busy;
      w_timeoutNext = 1'b0;
      w_ptrNext     = r_ptr;
`ifdef ARB_HOLD_TIMEOUT_EN
      w_cntNext     = r_cnt;
`endif
      case (r_state)
         ST_GRANT: begin
            if (!i_req[r_sel] || w_holdExpired) begin
               w_stateNext   = ST_GAP;
               w_gntNext     = 4'b0000;
               w_busyNext    = 1'b0;
               w_ptrNext     = r_sel + 2'd1;
               w_timeoutNext = i_req[r_sel];
            end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
               if (r_cnt != {CNT_W{1'b1}}) begin
                  w_cntNext = r_cnt + CNT_W'(1);
               end
`endif
            end
         end
         default: begin
            if (i_en && w_found) begin
               w_stateNext = ST_GRANT;
               w_gntNext   = 4'b0001 << w_winner;
               w_selNext   = w_winner;
               w_busyNext  = 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
               w_cntNext   = '0;
`endif
            end else begin
               w_stateNext = ST_IDLE;
               w_gntNext   = 4'b0000;
               w_busyNext  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_gnt     <= 4'b0000;
         r_sel     <= 2'd0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_ptr     <= 2'd0;
      end else begin
         r_state   <= w_stateNext;
         r_gnt     <= w_gntNext;
         r_sel     <= w_selNext;
         r_busy    <= w_busyNext;
         r_timeout <= w_timeoutNext;
         r_ptr     <= w_ptrNext;
      end
   end

`ifdef ARB_HOLD_TIMEOUT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cntNext;
      end
   end
`endif

   assign o_gnt     = r_gnt;
   assign o_sel     = r_sel;
   assign o_busy    = r_busy;
   assign o_timeout = r_timeout;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Scoreboard bench for mux4_rr_arbiter (MAX_HOLD = 4). On every falling edge
// the stimulus process drives the inputs, advances a behavioural model of
// the arbitration rules, and queues the outputs expected after the next
// rising edge. A separate monitor takes each expectation off the queue
// 1 time unit after the rising edge and compares it with the DUT outputs.
// Behaviour of the hold timeout follows ARB_HOLD_TIMEOUT_EN, the same
// macro the design uses.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       en = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       timeout;
   } expT;

   expT expQ[$];

   int compareCount  = 0;
   int mismatchCount = 0;
   int cycleNo       = 0;

   // Model state: mOwner is the current owner or -1 when no owner holds
   // the grant. mHeld counts the grant cycles the owner has had so far.
   int mOwner   = -1;
   int mSel     = 0;
   int mPtr     = 0;
   int mHeld    = 0;
   bit mTimeout = 1'b0;
   bit lastRs   = 1'b0;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .i_clk     (clk),
      .i_rst_n   (rstN),
      .i_en      (en),
      .i_req     (req),
      .o_gnt     (gnt),
      .o_sel     (sel),
      .o_busy    (busy),
      .o_timeout (timeout)
   );

   always #5 clk = ~clk;

   // Compare one expected output set with the DUT outputs and update
   // the counters.
   task automatic checkOutput(input string name, input expT exp, input expT act);
      compareCount++;
      if (act !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, expected gnt=%b sel=%0d busy=%b timeout=%b",
                  name, act.gnt, act.sel, act.busy, act.timeout,
                  exp.gnt, exp.sel, exp.busy, exp.timeout);
      end
   endtask

   // Move the model across one rising edge for the given input values.
   // IDLE and GAP need no separate treatment: whenever there is no owner,
   // the model arbitrates. The dead cycle between owners comes from
   // clearing the owner on release.
   task automatic modelStep(input logic rs, input logic e, input logic [3:0] q);
      if (!rs) begin
         mOwner = -1; mSel = 0; mPtr = 0; mHeld = 0; mTimeout = 1'b0;
      end else if (mOwner >= 0) begin
         mTimeout = 1'b0;
         if (!q[mOwner]) begin
            mPtr   = (mOwner + 1) % 4;
            mOwner = -1;
         end
`ifdef ARB_HOLD_TIMEOUT_EN
         else if (mHeld == MAX_HOLD) begin
            mPtr     = (mOwner + 1) % 4;
            mOwner   = -1;
            mTimeout = 1'b1;
         end
`endif
         else begin
            mHeld++;
         end
      end else begin
         mTimeout = 1'b0;
         if (e) begin
            for (int k = 0; k < 4; k++) begin
               if (mOwner < 0 && q[(mPtr + k) % 4]) begin
                  mOwner = (mPtr + k) % 4;
                  mSel   = mOwner;
                  mHeld  = 1;
               end
            end
         end
      end
   endtask

   function automatic expT modelOutputs();
      expT r;
      r.gnt     = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
      r.sel     = 2'(mSel);
      r.busy    = (mOwner >= 0);
      r.timeout = mTimeout;
      return r;
   endfunction

   // Drive one cycle of inputs on the falling edge and queue the
   // expected outputs for the next rising edge. A falling rst_n is
   // also checked at once, because the clear must not wait for a clock.
   task automatic applyStimulus(input logic rs, input logic e, input logic [3:0] q);
      @(negedge clk);
      rstN = rs;
      en   = e;
      req  = q;
      if (!rs && lastRs) begin
         #1;
         checkOutput("async reset", expT'(8'b0), {gnt, sel, busy, timeout});
      end
      lastRs = rs;
      modelStep(rs, e, q);
      expQ.push_back(modelOutputs());
   endtask

   // The monitor compares one queued expectation per rising edge.
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput($sformatf("cycle %0d", cycleNo), e, {gnt, sel, busy, timeout});
            cycleNo++;
         end
      end
   end

   initial begin
      logic [3:0] q;
      logic [3:0] qr;
      logic       er;
      logic       rr;

      $display("[TB] start");

      // Reset, then run with no requests
      repeat (2) applyStimulus(1'b0, 1'b0, 4'b0000);
      repeat (10) applyStimulus(1'b1, 1'b1, 4'b0000);

      // All four requesting; each owner drops its request after 3 grant cycles
      repeat (24) begin
         q = 4'b1111;
         if (mOwner >= 0 && mHeld == 3) q[mOwner] = 1'b0;
         applyStimulus(1'b1, 1'b1, q);
      end

      // Owner 1 releases, leaving the pointer at 2; the search with
      // 0011 must wrap around to requester 0
      repeat (2) applyStimulus(1'b1, 1'b1, 4'b0000);
      repeat (2) applyStimulus(1'b1, 1'b1, 4'b0010);
      applyStimulus(1'b1, 1'b1, 4'b0000);
      repeat (3) applyStimulus(1'b1, 1'b1, 4'b0011);
      repeat (2) applyStimulus(1'b1, 1'b1, 4'b0000);

      // Enable blocks new grants but does not end a grant in progress
      repeat (3) applyStimulus(1'b1, 1'b0, 4'b0100);
      applyStimulus(1'b1, 1'b1, 4'b0100);
      repeat (4) applyStimulus(1'b1, 1'b0, 4'b0100);
      applyStimulus(1'b1, 1'b0, 4'b0000);
      applyStimulus(1'b1, 1'b1, 4'b0000);

      // Two requesters held for a long time (hold-timeout path)
      repeat (14) applyStimulus(1'b1, 1'b1, 4'b0011);
      repeat (2) applyStimulus(1'b1, 1'b1, 4'b0000);

      // Owner releases in its 4th grant cycle, the same cycle in which
      // the hold limit would expire
      repeat (12) begin
         q = 4'b0001;
         if (mOwner == 0 && mHeld == 4) q = 4'b0000;
         applyStimulus(1'b1, 1'b1, q);
      end

      // Reset asserted mid-cycle while a grant is active
      repeat (3) applyStimulus(1'b1, 1'b1, 4'b1000);
      applyStimulus(1'b0, 1'b1, 4'b1000);
      repeat (3) applyStimulus(1'b1, 1'b1, 4'b1000);

      // Random traffic: request bits toggle now and then, enable is mostly
      // high, with rare resets
      qr = 4'b0000;
      repeat (400) begin
         qr = qr ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         er = ($urandom_range(0, 7) != 0);
         rr = ($urandom_range(0, 99) != 0);
         applyStimulus(rr, er, qr);
      end

      // Wait a few cycles, then verify that the monitor has taken
      // every expectation off the queue
      repeat (3) @(posedge clk);
      #2;
      compareCount++;
      if (expQ.size() != 0) begin
         mismatchCount++;
         $display("[TB] FAIL drain: %0d expectations left in queue, expected 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4:1 single-bit output mux between four requesters.
- Drives the mux 2-bit select and one-hot grants, and holds a grant until the owner releases it.
- Optional hold-timeout forces preemption of an owner that holds too long.
- Sits between the requester logic on ui_in and the mux select input in the same top-level design.

Parameters:
MAX_HOLD, 16, max cycles an owner may stay in GRANT before forced release (legal range 2..255; used only with the optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  arbitration enable; 0 blocks new grants
req  input  4  request per requester, level-sensitive, held while access is needed
gnt  output  4  one-hot grant, registered
sel  output  2  mux select = index of current or last owner, registered
busy  output  1  1 while in GRANT
timeout  output  1  one-cycle pulse when a grant is forcibly ended

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- All outputs are registered.
- Reset values: state=IDLE, gnt=0, sel=0, busy=0, timeout=0, ptr=0, hold counter=0.
- Reset asserted mid-grant clears everything immediately, with no GAP cycle.
- States:
  - IDLE: no owner.
  - GRANT: one owner.
  - GAP: one-cycle turnaround with gnt=0 so the mux output cannot glitch between owners.
- Arbitration is evaluated in IDLE and in GAP when en=1 and req!=0:
  - Winner = first set req bit searching ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - Next state GRANT. gnt=onehot(winner), sel=winner, busy=1, counter=0.
- Latency: req sampled high at edge k gives gnt high after edge k (1 cycle).
- en=0 in IDLE or GAP: stay in or go to IDLE; no grant is issued. en has no effect on a grant already in progress.
- GRANT to GAP happens when req[owner]=0, or on a hold timeout (optional feature).
- GRANT to GAP actions: gnt=0, busy=0, sel holds the owner index, ptr=(owner+1) mod 4 (2-bit wrap, 3 goes to 0).
- GAP to GRANT is immediate if arbitration succeeds; otherwise GAP goes to IDLE. There is exactly one dead cycle between consecutive owners.
- Requests from non-owners during GRANT are ignored and create no queueing state. They are re-evaluated in GAP.
- A requester that drops and raises req within GRANT while not owner is treated the same as holding it.
- Simultaneous owner release and timeout in the same cycle count as a release: timeout stays 0.
- Hold counter width is clog2(MAX_HOLD+1) bits. It increments once per GRANT cycle, saturates, and never wraps.

Optional Feature:
ARB_HOLD_TIMEOUT_EN:
- Defined:
  - In GRANT, if counter==MAX_HOLD-1 and req[owner] is still 1, go to GAP next edge.
  - Assert timeout for exactly that GAP cycle.
  - Owner holds exactly MAX_HOLD cycles. ptr advances past the owner so others get served.
- Undefined:
  - No counter logic. The grant is held until req[owner]=0.
  - timeout is tied to 0.
  - MAX_HOLD is ignored.

Test Plan:
- Reset then req=4'b0000 for 10 cycles -> gnt=0, sel=0, busy=0 throughout; async rst_n pulse mid-cycle clears outputs before the next edge.
- req=4'b1111 held, each owner drops its req 3 cycles after its grant, then re-raises it one cycle later -> grant order 0,1,2,3,0; gnt=0 for exactly 1 cycle between owners; sel follows 0,1,2,3,0.
- ptr=2 (after owner 1 released), req=4'b0011 -> requester 0 granted (wrap search 2,3,0); sel=0.
- en=0 with req=4'b0100 -> no grant; raise en -> gnt=4'b0100 one cycle later. Drop en during the grant -> grant persists until req[2]=0.
- ARB_HOLD_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held -> owner 0 busy for exactly 4 cycles, then timeout=1 for 1 cycle in GAP, then gnt=4'b0010. Without the macro, owner 0 holds indefinitely and timeout stays 0.
- ARB_HOLD_TIMEOUT_EN, MAX_HOLD=4, owner drops req on the 4th grant cycle -> transition to GAP with timeout=0.
